// File: rtl/gray_counter.sv
// gray_counter
// Dual binary/Gray pointer counter for one side of an asynchronous FIFO.
// The binary count addresses the FIFO RAM. The registered Gray count is the
// value that crosses into the other clock domain. The full and empty
// comparison logic lives outside this block.
//
// Parameters:
//   size    pointer width in bits (>= 3); RAM address width is size-1
//
// Ports:
//   clk     in   1        pointer-domain clock, rising edge
//   rst_n   in   1        asynchronous active-low reset
//   inc     in   1        increment request (push on write / pop on read)
//   status  in   1        inhibit (full on write side, empty on read side)
//   adr     out  size-1   binary RAM address, bin[size-2:0]
//   ptr     out  size     registered Gray pointer including the wrap bit
//
// Optional build macro:
//   GRAY_CNT_CHECK_EN  compiles in simulation-only assertions. It adds no
//                      ports and changes no logic.

module gray_counter #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            status,
  output logic [size-2:0] adr,
  output logic [size-1:0] ptr
);

  logic [size-1:0] bin_q;
  logic [size-1:0] bin_d;
  logic [size-1:0] ptr_q;
  logic [size-1:0] ptr_d;
  logic            step;

  // Next-state logic.
  // Advance by at most one per cycle, and only when not inhibited.
  // The Gray value is derived from the *next* binary value, so ptr can be
  // registered directly. This leaves no logic between the flop and the
  // clock-domain crossing.
  always_comb begin
    step  = inc & ~status;
    bin_d = bin_q + {{(size-1){1'b0}}, step};
    ptr_d = (bin_d >> 1) ^ bin_d;
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      ptr_q <= '0;
    end else begin
      bin_q <= bin_d;
      ptr_q <= ptr_d;
    end
  end

  assign adr = bin_q[size-2:0];
  assign ptr = ptr_q;

`ifdef GRAY_CNT_CHECK_EN
  // Gray pointer moves by at most one bit per clock.
  a_one_bit: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(ptr_q ^ $past(ptr_q)) <= 1);

  // Gray pointer always tracks the binary count.
  a_gray_match: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_q == (bin_q ^ (bin_q >> 1)));

  // An inhibited request leaves the state untouched.
  a_hold_blocked: assert property (@(posedge clk) disable iff (!rst_n)
    $past(inc & status) |-> (bin_q == $past(bin_q)) && (ptr_q == $past(ptr_q)));
`else
  // Checks not compiled in; the logic is identical either way.
`endif

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter
// Testbench for gray_counter with size=8. A reference count tracks the number
// of accepted increments with plain modular arithmetic. Every expected address
// and Gray pointer is derived from that count.

module tb_gray_counter;

  localparam int size = 8;

  logic            clk;
  logic            rst_n;
  logic            inc;
  logic            status;
  logic [size-2:0] adr;
  logic [size-1:0] ptr;

  int unsigned     model_count;
  logic [size-1:0] prev_ptr;
  int              tests_run;
  int              tests_failed;

  gray_counter #(.size(size)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (inc),
    .status (status),
    .adr    (adr),
    .ptr    (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference values from the accepted-increment count.
  function automatic logic [size-2:0] exp_adr(input int unsigned n);
    return (size-1)'(n % (1 << (size-1)));
  endfunction

  function automatic logic [size-1:0] exp_ptr(input int unsigned n);
    int unsigned b;
    b = n % (1 << size);
    return size'(b ^ (b / 2));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and check the result after the edge.
  task automatic applyStimulus(input logic i, input logic s);
    @(negedge clk);
    inc    = i;
    status = s;
    prev_ptr = ptr;
    @(posedge clk);
    #1;
    if (i && !s) model_count++;
    checkOutput("adr", 32'(adr), 32'(exp_adr(model_count)));
    checkOutput("ptr", 32'(ptr), 32'(exp_ptr(model_count)));
    checkOutput("bits_changed", 32'($countones(ptr ^ prev_ptr)),
                (i && !s) ? 32'd1 : 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_count  = 0;
    inc          = 1'b0;
    status       = 1'b0;
    rst_n        = 1'b1;

    // Asynchronous reset at a non-edge time.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_adr", 32'(adr), 32'd0);
    checkOutput("reset_ptr", 32'(ptr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold_ptr", 32'(ptr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count 5.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("count5_adr", 32'(adr), 32'd5);
    checkOutput("count5_ptr", 32'(ptr), 32'h07);

    // Blocked by status.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1);
    checkOutput("blocked_adr", 32'(adr), 32'd5);
    checkOutput("blocked_ptr", 32'(ptr), 32'h07);

    // Reset mid-count, between edges, while inc is active.
    @(posedge clk);
    #3;
    inc    = 1'b1;
    status = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("midreset_adr", 32'(adr), 32'd0);
    checkOutput("midreset_ptr", 32'(ptr), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midreset_held_ptr", 32'(ptr), 32'd0);
    @(negedge clk);
    inc   = 1'b0;
    rst_n = 1'b1;
    model_count = 0;

    // First increment after reset.
    applyStimulus(1'b1, 1'b0);
    checkOutput("first_inc_ptr", 32'(ptr), 32'h01);

    // Depth boundary at 128 increments.
    for (int k = 1; k < 128; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("depth_adr", 32'(adr), 32'd0);
    checkOutput("depth_ptr", 32'(ptr), 32'hC0);

    // Step 255, then the full wrap at 256.
    for (int k = 128; k < 255; k++) applyStimulus(1'b1, 1'b0);
    checkOutput("step255_ptr", 32'(ptr), 32'h80);
    applyStimulus(1'b1, 1'b0);
    checkOutput("wrap_adr", 32'(adr), 32'd0);
    checkOutput("wrap_ptr", 32'(ptr), 32'h00);
    checkOutput("wrap_flip", 32'(ptr ^ prev_ptr), 32'h80);

    // Idle: no request, status toggling randomly.
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    checkOutput("idle_ptr", 32'(ptr), 32'h00);

    // Random inc/status mix, including further wraps.
    for (int k = 0; k < 600; k++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
